// File: rtl/spi_xfer_ctrl.sv
// SPI master transfer controller: sequences slave select, SCLK and the
// load/shift/sample strobes for one DATA_W-bit frame, with optional back-to-back frames.
module spi_xfer_ctrl #(
  parameter int DATA_W = 16,
  parameter int NSS    = 4,
  parameter int DIV_W  = 8,
  localparam int SEL_W = (NSS > 1) ? $clog2(NSS) : 1
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             send,
  input  logic             keep_ss,
  input  logic             cpol,
  input  logic             cpha,
  input  logic [DIV_W-1:0] div,
  input  logic [SEL_W-1:0] ss_sel,
  output logic             sclk,
  output logic [NSS-1:0]   ss_n,
  output logic             load,
  output logic             shift_en,
  output logic             sample_en,
  output logic             busy,
  output logic             done
);

  localparam int EDGES = 2 * DATA_W;
  localparam int EC_W  = $clog2(EDGES + 1);

  typedef enum logic [2:0] {IDLE, LOAD, LEAD, XFER, TRAIL, DONE} state_t;

  state_t           state, state_n;
  logic [DIV_W-1:0] hcnt, hcnt_n, div_q;
  logic [EC_W-1:0]  ecnt, ecnt_n;
  logic             cpol_q, cpha_q;
  logic             term, edge_n, samp_n, shift_n;

  function automatic logic [NSS-1:0] sel_dec(input logic [SEL_W-1:0] s);
    sel_dec = '1;
    for (int unsigned i = 0; i < NSS; i++)
      if (s == SEL_W'(i)) sel_dec[i] = 1'b0;
  endfunction

  assign term = (hcnt == div_q);

  always_comb begin
    state_n = state;
    hcnt_n  = '0;
    ecnt_n  = ecnt;
    case (state)
      IDLE: begin
        ecnt_n = '0;
        if (send) state_n = LOAD;
      end
      LOAD: begin
        ecnt_n  = '0;
        state_n = LEAD;
      end
      LEAD: begin
        if (term) state_n = XFER;
        else      hcnt_n  = hcnt + 1'b1;
      end
      XFER: begin
        if (term) begin
          ecnt_n = ecnt + 1'b1;
          if (ecnt == EC_W'(EDGES - 1)) state_n = TRAIL;
        end else begin
          hcnt_n = hcnt + 1'b1;
        end
      end
      TRAIL: begin
        if (term) begin
          state_n = DONE;
          ecnt_n  = '0;
        end else begin
          hcnt_n = hcnt + 1'b1;
        end
      end
      DONE: begin
        ecnt_n  = '0;
        state_n = (send && keep_ss) ? LOAD : IDLE;
      end
      default: begin
        ecnt_n  = '0;
        state_n = IDLE;
      end
    endcase
  end

  // Strobes are registered, so they are decoded from the next-cycle state:
  // the next cycle ends in SCLK edge number ecnt_n+1 (odd = leading).
  always_comb begin
    edge_n  = (state_n == XFER) && (hcnt_n == div_q);
    samp_n  = edge_n && (ecnt_n[0] == cpha_q);
    shift_n = edge_n && (ecnt_n[0] != cpha_q) &&
              !(cpha_q ? (ecnt_n == '0) : (ecnt_n == EC_W'(EDGES - 1)));
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state     <= IDLE;
      hcnt      <= '0;
      ecnt      <= '0;
      div_q     <= '0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      sclk      <= 1'b0;
      ss_n      <= '1;
      load      <= 1'b0;
      shift_en  <= 1'b0;
      sample_en <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      hcnt      <= hcnt_n;
      ecnt      <= ecnt_n;
      load      <= (state_n == LOAD);
      shift_en  <= shift_n;
      sample_en <= samp_n;
      busy      <= (state_n != IDLE);
      done      <= (state_n == DONE);

      if (state_n == LOAD) begin
        cpol_q <= cpol;
        cpha_q <= cpha;
        div_q  <= div;
        ss_n   <= sel_dec(ss_sel);
      end else if (state_n == IDLE) begin
        ss_n <= '1;
      end

      case (state)
        IDLE:              sclk <= cpol;
        XFER:              sclk <= term ? ~sclk : sclk;
        LOAD, LEAD, TRAIL: sclk <= cpol_q;
        DONE:              sclk <= (state_n == LOAD) ? cpol : cpol_q;
        default:           sclk <= 1'b0;
      endcase
    end
  end

endmodule
